huffman_encoder: RTL

Streaming Huffman encoder, the transmit-side counterpart of `huffman_decoder`. It accepts 8-bit ASCII symbols over a valid/ready handshake and emits the serial code bitstream that `huffman_decoder` consumes, using the same 6-symbol rank-ordered truncated-unary code. It sits between a symbol source (e.g. a message buffer) and a bit sink (a serializer or the decoder bench), and supports back-pressure on both sides.

---
 rtl/huffman_encoder_if.sv | 27 ++
 rtl/huffman_encoder.sv | 119 +++++++++++
 2 files changed

// File: rtl/huffman_encoder_if.sv
// Handshake bundle between a symbol source / bit sink and the Huffman encoder.
// The master drives symbols and start; the slave (encoder) drives the bit stream.
interface huffman_encoder_if;
    logic        start;
    logic [47:0] encoding;
    logic [7:0]  sym_data;
    logic        sym_valid;
    logic        sym_last;
    logic        sym_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] bit_count;

    modport master (
        output start, encoding, sym_data, sym_valid, sym_last, bit_ready,
        input  sym_ready, bit_out, bit_valid, busy, done, error, bit_count
    );

    modport slave (
        input  start, encoding, sym_data, sym_valid, sym_last, bit_ready,
        output sym_ready, bit_out, bit_valid, busy, done, error, bit_count
    );
endinterface

// File: rtl/huffman_encoder.sv
// Streaming encoder for a 6-symbol rank-ordered truncated-unary code:
// rank k < 5 sends k ones then a zero, rank 5 sends five ones.
//
// state    | meaning
// IDLE     | waiting for start, table not in use
// WAIT_SYM | ready for the next symbol
// EMIT     | serialising the code of the latched rank
// DONE     | one-cycle done pulse, then back to IDLE
module huffman_encoder (
    input  logic             clock,
    input  logic             reset,
    huffman_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_SYM, EMIT, DONE} state_t;

    state_t      state;
    logic [7:0]  sym_table [6];
    logic [2:0]  rank_q;
    logic [2:0]  idx_q;
    logic        last_q;
    logic        bit_valid_q;
    logic        bit_out_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] bit_count_q;

    logic        match_hit;
    logic [2:0]  match_rank;
    logic [2:0]  final_idx;

    // Scan from the top rank down so a duplicated entry resolves to its lowest rank.
    always_comb begin
        match_hit  = 1'b0;
        match_rank = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (sym_table[i] == bus.sym_data) begin
                match_hit  = 1'b1;
                match_rank = 3'(i);
            end
        end
    end

    assign final_idx = (rank_q == 3'd5) ? 3'd4 : rank_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            for (int i = 0; i < 6; i++) sym_table[i] <= 8'd0;
            rank_q      <= 3'd0;
            idx_q       <= 3'd0;
            last_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            bit_count_q <= 16'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 6; i++) sym_table[i] <= bus.encoding[(5 - i) * 8 +: 8];
                        bit_count_q <= 16'd0;
                        state       <= WAIT_SYM;
                    end
                end
                WAIT_SYM: begin
                    if (bus.sym_valid) begin
                        if (match_hit) begin
                            rank_q      <= match_rank;
                            idx_q       <= 3'd0;
                            last_q      <= bus.sym_last;
                            bit_valid_q <= 1'b1;
                            bit_out_q   <= (match_rank != 3'd0);
                            state       <= EMIT;
                        end else begin
                            error_q <= 1'b1;
                            if (bus.sym_last) begin
                                done_q <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (bus.bit_ready) begin
                        bit_count_q <= bit_count_q + 16'd1;
                        idx_q       <= idx_q + 3'd1;
                        if (idx_q == final_idx) begin
                            bit_valid_q <= 1'b0;
                            bit_out_q   <= 1'b0;
                            if (last_q) begin
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                state <= WAIT_SYM;
                            end
                        end else begin
                            bit_out_q <= ((idx_q + 3'd1) < rank_q) || (rank_q == 3'd5);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sym_ready = (state == WAIT_SYM);
    assign bus.busy      = (state != IDLE);
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.bit_count = bit_count_q;
endmodule
